// File: rtl/fifo_pkg.sv
// Shared definitions for the ingress byte queue.
//   ingress_state_t : handshake FSM states toward the deserializer
//   DEPTH_DEF       : default queue depth (entries)
//   DATA_W_DEF      : default byte width
//   PTR_W           : pointer width for the default depth
package fifo_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_LOW = 1'b1
  } ingress_state_t;

  localparam int unsigned DEPTH_DEF  = 8;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned PTR_W      = $clog2(DEPTH_DEF);

endpackage

// File: rtl/fifo_ingress_ctrl_sync_ff.sv
// Multi-stage flop chain that brings an asynchronous level into the local
// clock domain.
//   clk   : destination clock
//   reset : asynchronous, active-high; clears every stage
//   d     : asynchronous input level
//   q     : synchronised level, STAGES clock edges behind d
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/fifo_ingress_ctrl.sv
// Byte queue with an integrated 4-phase handshake toward the deserializer.
// Each byte presented on data_ready_in/data_in is captured once, acknowledged
// on ack_out and stored in a circular buffer; each rising edge of dequeue_in
// pops one byte to data_out.
//   clk_10KHz     : queue clock
//   reset         : asynchronous, active-high
//   data_ready_in : deserializer byte valid (foreign domain, level)
//   data_in       : deserializer byte, held stable while data_ready_in=1
//   ack_out       : 4-phase acknowledge back to the deserializer
//   dequeue_in    : pop request (asynchronous level, one pop per rise)
//   data_out      : last popped byte
//   len_out       : current occupancy 0..DEPTH
//   full_out      : len_out == DEPTH
//   empty_out     : len_out == 0
module fifo_ingress_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_10KHz,
  input  logic              reset,
  input  logic              data_ready_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_out,
  input  logic              dequeue_in,
  output logic [DATA_W-1:0] data_out,
  output logic [LEN_W-1:0]  len_out,
  output logic              full_out,
  output logic              empty_out
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic              rdy_s;
  logic              deq_s;
  logic              deq_s_d;
  logic              pop_req;
  ingress_state_t    state;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] mem [DEPTH];

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_rdy (
    .clk   (clk_10KHz),
    .reset (reset),
    .d     (data_ready_in),
    .q     (rdy_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_deq (
    .clk   (clk_10KHz),
    .reset (reset),
    .d     (dequeue_in),
    .q     (deq_s)
  );

  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) deq_s_d <= 1'b0;
    else       deq_s_d <= deq_s;
  end

  assign pop_req = deq_s & ~deq_s_d;

  // Write and pop are both qualified on the pre-edge flags: a full queue
  // refuses the write (retried next cycle), an empty queue ignores the pop.
  assign wr_en = (state == IDLE) & rdy_s & ~full_out;
  assign rd_en = pop_req & ~empty_out;

  always_comb begin
    cnt_nxt = cnt;
    case ({wr_en, rd_en})
      2'b10:   cnt_nxt = cnt + CW'(1);
      2'b01:   cnt_nxt = cnt - CW'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ack_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en) begin
            ack_out <= 1'b1;
            state   <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!rdy_s) begin
            ack_out <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          ack_out <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      full_out  <= 1'b0;
      empty_out <= 1'b1;
      data_out  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) begin
        rd_ptr   <= rd_ptr + AW'(1);
        data_out <= mem[rd_ptr];
      end
      cnt       <= cnt_nxt;
      full_out  <= (cnt_nxt == CW'(DEPTH));
      empty_out <= (cnt_nxt == '0);
    end
  end

  // Storage carries no reset; contents are only read after being written.
  always_ff @(posedge clk_10KHz) begin
    if (wr_en) mem[wr_ptr] <= data_in;
  end

  assign len_out = LEN_W'(cnt);

endmodule
